// File: rtl/c3lib_dbnc_filter_pkg.sv
// c3lib_dbnc_filter_pkg
//   Shared definitions for the debounce filter: the four-state FSM encoding,
//   default parameter constants and small state-decode helpers.
package c3lib_dbnc_filter_pkg;

    typedef enum logic [1:0] {
        S_LO  = 2'd0,   // settled low
        S_QHI = 2'd1,   // low, qualifying a rise
        S_HI  = 2'd2,   // settled high
        S_QLO = 2'd3    // high, qualifying a fall
    } dbnc_state_e;

    localparam int DBNC_STABLE_CYC = 4;
    localparam int DBNC_CNT_W      = 4;
    localparam int DBNC_GLT_W      = 8;

    // Filtered level is high while settled high or while a fall is still unproven.
    function automatic logic dbnc_is_high(input dbnc_state_e s);
        return (s == S_HI) || (s == S_QLO);
    endfunction

    function automatic logic dbnc_is_qual(input dbnc_state_e s);
        return (s == S_QHI) || (s == S_QLO);
    endfunction

endpackage

// File: rtl/c3lib_sat_ctr.sv
// c3lib_sat_ctr
//   Saturating up-counter with synchronous active-low clear.
//   Ports:
//     clk   - clock
//     clr_n - synchronous clear, active-low (wins over inc)
//     inc   - increment enable for this cycle
//     cnt   - current count, sticks at all-ones
module c3lib_sat_ctr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (v == CNT_MAX) ? CNT_MAX : v + WIDTH'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= sat_inc(cnt);
        end
    end

endmodule

// File: rtl/c3lib_dbnc_filter.sv
// c3lib_dbnc_filter
//   Debounce filter for a synchronous 1-bit level. A new level is accepted
//   only after STABLE_CYC consecutive identical samples; shorter excursions
//   are rejected and counted as glitches.
//   Ports:
//     clk        - clock, all state on rising edge
//     rst_n      - synchronous reset, active-low
//     en         - filter enable; low freezes all state
//     data_in    - raw level (already synchronous)
//     data_out   - filtered level (registered)
//     rise_pulse - one-cycle strobe with data_out 0->1
//     fall_pulse - one-cycle strobe with data_out 1->0
//     qual_busy  - high while a transition is being qualified
//     glitch_cnt - saturating count of rejected transitions
module c3lib_dbnc_filter
    import c3lib_dbnc_filter_pkg::*;
#(
    parameter int STABLE_CYC = DBNC_STABLE_CYC,
    parameter int CNT_W      = DBNC_CNT_W,
    parameter int GLT_W      = DBNC_GLT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             data_in,
    output logic             data_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic             qual_busy,
    output logic [GLT_W-1:0] glitch_cnt
);

    // Count value at which the next matching sample completes qualification.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYC - 1);

    dbnc_state_e      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             glitch;

    // Next-state / qualification counter. With en low everything keeps its
    // value, so the held cnt is where qualification resumes.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        glitch    = 1'b0;
        if (en) begin
            case (state)
                S_LO: begin
                    if (data_in) begin
                        if (STABLE_CYC == 1) begin
                            state_nxt = S_HI;
                        end else begin
                            state_nxt = S_QHI;
                            cnt_nxt   = CNT_W'(1);
                        end
                    end
                end
                S_QHI: begin
                    if (data_in) begin
                        if (cnt == CNT_LAST) begin
                            state_nxt = S_HI;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + CNT_W'(1);
                        end
                    end else begin
                        state_nxt = S_LO;
                        cnt_nxt   = '0;
                        glitch    = 1'b1;
                    end
                end
                S_HI: begin
                    if (!data_in) begin
                        if (STABLE_CYC == 1) begin
                            state_nxt = S_LO;
                        end else begin
                            state_nxt = S_QLO;
                            cnt_nxt   = CNT_W'(1);
                        end
                    end
                end
                S_QLO: begin
                    if (!data_in) begin
                        if (cnt == CNT_LAST) begin
                            state_nxt = S_LO;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + CNT_W'(1);
                        end
                    end else begin
                        state_nxt = S_HI;
                        cnt_nxt   = '0;
                        glitch    = 1'b1;
                    end
                end
                default: begin
                    state_nxt = S_LO;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so they line
    // up with the state register. A glitch returns to the settled state it
    // came from, which never counts as an entry into S_HI/S_LO for pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_LO;
            cnt        <= '0;
            data_out   <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            qual_busy  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            data_out   <= dbnc_is_high(state_nxt);
            qual_busy  <= dbnc_is_qual(state_nxt);
            rise_pulse <= (state_nxt == S_HI) && (state == S_LO || state == S_QHI);
            fall_pulse <= (state_nxt == S_LO) && (state == S_HI || state == S_QLO);
        end
    end

    c3lib_sat_ctr #(
        .WIDTH (GLT_W)
    ) u_glitch_ctr (
        .clk   (clk),
        .clr_n (rst_n),
        .inc   (glitch),
        .cnt   (glitch_cnt)
    );

endmodule

// File: tb/tb_c3lib_dbnc_filter.sv
// tb_c3lib_dbnc_filter
//   Directed bench for c3lib_dbnc_filter (STABLE_CYC=4, CNT_W=4, GLT_W=8).
//   The reference model tracks the accepted level plus the length of the
//   current run of samples that disagree with it; a run reaching STABLE_CYC
//   flips the level, a run broken early is a glitch.
module tb_c3lib_dbnc_filter;

    localparam int STABLE_CYC = 4;
    localparam int CNT_W      = 4;
    localparam int GLT_W      = 8;
    localparam int GMAX       = (1 << GLT_W) - 1;

    logic             clk     = 1'b0;
    logic             rst_n   = 1'b0;
    logic             en      = 1'b0;
    logic             data_in = 1'b0;
    logic             data_out;
    logic             rise_pulse;
    logic             fall_pulse;
    logic             qual_busy;
    logic [GLT_W-1:0] glitch_cnt;

    always #5 clk = ~clk;

    c3lib_dbnc_filter #(
        .STABLE_CYC (STABLE_CYC),
        .CNT_W      (CNT_W),
        .GLT_W      (GLT_W)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .data_in    (data_in),
        .data_out   (data_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .qual_busy  (qual_busy),
        .glitch_cnt (glitch_cnt)
    );

    int tests = 0;
    int fails = 0;
    int n_rise = 0;
    int n_fall = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model
    int m_lvl  = 0;
    int m_run  = 0;
    int m_glt  = 0;
    int m_rise = 0;
    int m_fall = 0;

    always @(posedge clk) begin
        m_rise = 0;
        m_fall = 0;
        if (!rst_n) begin
            m_lvl = 0;
            m_run = 0;
            m_glt = 0;
        end else if (en) begin
            if (int'(data_in) != m_lvl) begin
                m_run++;
                if (m_run == STABLE_CYC) begin
                    m_lvl = 1 - m_lvl;
                    m_run = 0;
                    if (m_lvl == 1) m_rise = 1;
                    else            m_fall = 1;
                end
            end else begin
                if (m_run > 0 && m_glt < GMAX) m_glt++;
                m_run = 0;
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_on) begin
            check("data_out",   data_out,   m_lvl);
            check("rise_pulse", rise_pulse, m_rise);
            check("fall_pulse", fall_pulse, m_fall);
            check("qual_busy",  qual_busy,  (m_run > 0) ? 1 : 0);
            check("glitch_cnt", glitch_cnt, m_glt);
            n_rise += int'(rise_pulse);
            n_fall += int'(fall_pulse);
        end
    end

    task automatic cyc(input bit e, input bit d);
        en      = e;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    int p0;

    initial begin
        // Reset state
        rst_n = 1'b0;
        cyc(0, 0);
        cyc(1, 1);
        chk_on = 1'b1;
        check("rst_dout",   data_out,   0);
        check("rst_busy",   qual_busy,  0);
        check("rst_glitch", glitch_cnt, 0);
        check("rst_rise",   rise_pulse, 0);
        check("rst_fall",   fall_pulse, 0);
        rst_n = 1'b1;
        cyc(1, 0);
        cyc(1, 0);

        // Clean rise: busy for 3 cycles, level on the 4th high sample
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1);
            check("qhi_busy", qual_busy, 1);
            check("qhi_dout", data_out,  0);
        end
        cyc(1, 1);
        check("rise_dout",  data_out,   1);
        check("rise_pulse", rise_pulse, 1);
        check("rise_busy",  qual_busy,  0);
        cyc(1, 1);
        check("rise_1cyc",  rise_pulse, 0);
        check("hi_hold",    data_out,   1);

        // Clean fall back to low
        repeat (4) cyc(1, 0);
        check("fall_dout",  data_out,   0);
        check("fall_pulse", fall_pulse, 1);
        cyc(1, 0);

        // Short high burst rejected
        p0 = n_rise + n_fall;
        repeat (3) cyc(1, 1);
        cyc(1, 0);
        check("glitch_1",      glitch_cnt, 1);
        check("glitch_1_dout", data_out,   0);
        cyc(1, 0);
        check("glitch_1_nopulse", n_rise + n_fall - p0, 0);

        // From high: low 2, high 1 (glitch), then low 4 (fall)
        repeat (4) cyc(1, 1);
        check("hi_again", data_out, 1);
        cyc(1, 0);
        cyc(1, 0);
        check("qlo_busy", qual_busy, 1);
        check("qlo_dout", data_out,  1);
        cyc(1, 1);
        check("glitch_2",      glitch_cnt, 2);
        check("glitch_2_dout", data_out,   1);
        check("glitch_2_busy", qual_busy,  0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0);
            check("qlo_hold", data_out, 1);
        end
        cyc(1, 0);
        check("fall2_dout",  data_out,   0);
        check("fall2_pulse", fall_pulse, 1);
        cyc(1, 0);
        check("fall2_1cyc",  fall_pulse, 0);

        // Enable dropped mid-qualification, then resumed
        cyc(1, 1);
        cyc(1, 1);
        for (int i = 0; i < 5; i++) begin
            cyc(0, (i % 2) == 0);
            check("frz_busy",   qual_busy,  1);
            check("frz_dout",   data_out,   0);
            check("frz_glitch", glitch_cnt, 2);
            check("frz_rise",   rise_pulse, 0);
            check("frz_fall",   fall_pulse, 0);
        end
        cyc(1, 1);
        check("resume_dout", data_out, 0);
        cyc(1, 1);
        check("resume_rise", data_out,   1);
        check("resume_puls", rise_pulse, 1);

        // Reset while settled high: no fall pulse
        rst_n = 1'b0;
        cyc(1, 1);
        check("rsthi_dout",   data_out,   0);
        check("rsthi_fall",   fall_pulse, 0);
        check("rsthi_glitch", glitch_cnt, 0);
        rst_n = 1'b1;
        cyc(1, 0);

        // Reset in S_QHI with cnt=2
        cyc(1, 1);
        cyc(1, 1);
        check("pre_rst_busy", qual_busy, 1);
        rst_n = 1'b0;
        cyc(1, 1);
        check("rstq_busy", qual_busy,  0);
        check("rstq_dout", data_out,   0);
        check("rstq_rise", rise_pulse, 0);
        rst_n = 1'b1;
        // Full qualification needed after reset
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1);
            check("postrst_dout", data_out, 0);
        end
        cyc(1, 1);
        check("postrst_rise", data_out,   1);
        check("postrst_puls", rise_pulse, 1);
        repeat (4) cyc(1, 0);
        check("postrst_low", data_out, 0);

        // Glitch counter saturation
        for (int i = 0; i < 300; i++) begin
            cyc(1, 1);
            cyc(1, 0);
        end
        check("glitch_sat", glitch_cnt, 255);
        cyc(1, 1);
        cyc(1, 0);
        check("glitch_sat_hold", glitch_cnt, 255);
        check("glitch_sat_dout", data_out,   0);

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
